// File: rtl/single_port_ram_if.sv
// rtl/single_port_ram_if.sv - RAM bus bundle for single_port_ram (parity_err under SINGLE_PORT_RAM_PARITY_EN)
interface single_port_ram_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  write_enb;
  logic                  read_enb;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
`ifdef SINGLE_PORT_RAM_PARITY_EN
  logic                  parity_err;

  modport master (
    output data_in, write_enb, read_enb, address,
    input  data_out, data_valid, parity_err
  );

  modport slave (
    input  data_in, write_enb, read_enb, address,
    output data_out, data_valid, parity_err
  );
`else
  modport master (
    output data_in, write_enb, read_enb, address,
    input  data_out, data_valid
  );

  modport slave (
    input  data_in, write_enb, read_enb, address,
    output data_out, data_valid
  );
`endif
endinterface

// File: rtl/single_port_ram.sv
// rtl/single_port_ram.sv - register-based single-port RAM, read-first, 1-cycle read; parity via SINGLE_PORT_RAM_PARITY_EN
module single_port_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  single_port_ram_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef SINGLE_PORT_RAM_PARITY_EN
  localparam int WORD_WIDTH = DATA_WIDTH + 1;
`else
  localparam int WORD_WIDTH = DATA_WIDTH;
`endif

  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic [WORD_WIDTH-1:0] wr_word;
  logic [WORD_WIDTH-1:0] rd_word;

  // Stored parity bit sits above the data so a consistent word XORs to 0.
`ifdef SINGLE_PORT_RAM_PARITY_EN
  assign wr_word = {^bus.data_in, bus.data_in};
`else
  assign wr_word = bus.data_in;
`endif
  assign rd_word = mem[bus.address];

  // Nonblocking update of mem gives read-first on a same-address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      bus.data_out   <= '0;
      bus.data_valid <= 1'b0;
`ifdef SINGLE_PORT_RAM_PARITY_EN
      bus.parity_err <= 1'b0;
`endif
    end else begin
      if (bus.write_enb) begin
        mem[bus.address] <= wr_word;
      end
      if (bus.read_enb) begin
        bus.data_out   <= rd_word[DATA_WIDTH-1:0];
        bus.data_valid <= 1'b1;
`ifdef SINGLE_PORT_RAM_PARITY_EN
        bus.parity_err <= ^rd_word;
`endif
      end else begin
        bus.data_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_single_port_ram.sv
// tb/tb_single_port_ram.sv - directed self-checking bench for single_port_ram
module tb_single_port_ram;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  single_port_ram_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  single_port_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Apply inputs, then step past the next rising edge so outputs are settled.
  task automatic cycle(input logic rst, input logic we, input logic re,
                       input logic [3:0] addr, input logic [7:0] din);
    reset         = rst;
    bus.write_enb = we;
    bus.read_enb  = re;
    bus.address   = addr;
    bus.data_in   = din;
    @(posedge clk);
    #1;
  endtask

  task automatic read_expect(input string tag, input logic [3:0] addr, input logic [7:0] exp);
    cycle(1'b0, 1'b0, 1'b1, addr, 8'h00);
    check_eq(tag, {24'd0, bus.data_out}, {24'd0, exp});
    check_eq({tag, "_valid"}, {31'd0, bus.data_valid}, 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset         = 1'b1;
    bus.write_enb = 1'b0;
    bus.read_enb  = 1'b0;
    bus.address   = '0;
    bus.data_in   = '0;
    #1;

    // 1. reset for two cycles, read request during reset is ignored
    cycle(1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
    cycle(1'b1, 1'b0, 1'b1, 4'd5, 8'h00);
    check_eq("rst_data_out", {24'd0, bus.data_out}, 32'd0);
    check_eq("rst_valid", {31'd0, bus.data_valid}, 32'd0);
    for (int a = 0; a < 16; a++) begin
      read_expect($sformatf("rst_rd%0d", a), a[3:0], 8'h00);
    end

    // 2. write then read
    cycle(1'b0, 1'b1, 1'b0, 4'd3, 8'hA5);
    check_eq("wr_no_valid", {31'd0, bus.data_valid}, 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 4'd15, 8'h5A);
    read_expect("rd_a3", 4'd3, 8'hA5);
    read_expect("rd_a15", 4'd15, 8'h5A);

    // 3. read-first collision
    cycle(1'b0, 1'b1, 1'b0, 4'd7, 8'h11);
    cycle(1'b0, 1'b1, 1'b1, 4'd7, 8'h22);
    check_eq("coll_old", {24'd0, bus.data_out}, 32'h11);
    check_eq("coll_valid", {31'd0, bus.data_valid}, 32'd1);
    read_expect("coll_new", 4'd7, 8'h22);

    // 4. hold behaviour
    read_expect("hold_rd", 4'd3, 8'hA5);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b0, 1'b0, 4'bxxxx, 8'h00);
      check_eq($sformatf("hold_data%0d", k), {24'd0, bus.data_out}, 32'hA5);
      check_eq($sformatf("hold_valid%0d", k), {31'd0, bus.data_valid}, 32'd0);
    end

    // 5. fill, verify, then reset mid-write
    for (int a = 0; a < 16; a++) begin
      cycle(1'b0, 1'b1, 1'b0, a[3:0], a[7:0] ^ 8'hFF);
    end
    for (int a = 0; a < 16; a++) begin
      read_expect($sformatf("fill_rd%0d", a), a[3:0], a[7:0] ^ 8'hFF);
    end
    cycle(1'b1, 1'b1, 1'b1, 4'd4, 8'h77);
    check_eq("midrst_data", {24'd0, bus.data_out}, 32'd0);
    check_eq("midrst_valid", {31'd0, bus.data_valid}, 32'd0);
    for (int a = 0; a < 16; a++) begin
      read_expect($sformatf("post_rst_rd%0d", a), a[3:0], 8'h00);
    end

`ifdef SINGLE_PORT_RAM_PARITY_EN
    // 6. parity: 0x03 stores parity 0; flipping bit 0 breaks it
    check_eq("par_rst", {31'd0, bus.parity_err}, 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 4'd0, 8'h03);
    cycle(1'b0, 1'b1, 1'b0, 4'd1, 8'h07);
    read_expect("par_clean0", 4'd0, 8'h03);
    check_eq("par_clean0_err", {31'd0, bus.parity_err}, 32'd0);
    dut.mem[0][0] = 1'b0;
    read_expect("par_bad_data", 4'd0, 8'h02);
    check_eq("par_bad_err", {31'd0, bus.parity_err}, 32'd1);
    read_expect("par_a1", 4'd1, 8'h07);
    check_eq("par_a1_err", {31'd0, bus.parity_err}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
